// File: rtl/iram_axi_mp_pkg.sv
// Shared constants for the instruction RAM: AXI response codes, bus widths,
// default depth, and a ceil(log2) helper for sizing address fields.
package iram_axi_mp_pkg;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam int INST_ADDR_W = 32;
  localparam int MEM_W       = 32;
  localparam int IRAM_SIZE   = 4096;

  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/iram_axi_mp_dpram.sv
// Dual-port RAM: port A registered read-only, port B registered read with
// byte-masked write. Both ports are read-first on a same-address collision.
module iram_axi_mp_dpram
  import iram_axi_mp_pkg::*;
#(
  parameter int RAM_WIDTH = 32,
  parameter int RAM_DEPTH = 4096,
  parameter int ADDR_W    = clogb2(RAM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   ena_i,
  input  logic [ADDR_W-1:0]      addra_i,
  output logic [RAM_WIDTH-1:0]   douta_o,
  input  logic                   enb_i,
  input  logic [RAM_WIDTH/8-1:0] web_i,
  input  logic [ADDR_W-1:0]      addrb_i,
  input  logic [RAM_WIDTH-1:0]   dinb_i,
  output logic [RAM_WIDTH-1:0]   doutb_o
);
  logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];

  always_ff @(posedge clk) begin
    if (ena_i) douta_o <= mem_q[addra_i];
  end

  always_ff @(posedge clk) begin
    if (enb_i) begin
      doutb_o <= mem_q[addrb_i];
      for (int i = 0; i < RAM_WIDTH / 8; i++) begin
        if (web_i[i]) mem_q[addrb_i][8*i +: 8] <= dinb_i[8*i +: 8];
      end
    end
  end
endmodule

// File: rtl/iram_axi_mp.sv
// Parametrised instruction RAM: port A feeds core fetch, port B is an AXI4-Lite
// slave. Define IRAM_SLVERR_EN to answer out-of-range AXI accesses with SLVERR.
module iram_axi_mp
  import iram_axi_mp_pkg::*;
#(
  parameter int          DEPTH     = IRAM_SIZE,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          RST_HOLD  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_n_i,
  input  logic        iram_rd_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        iram_hold_o,
  input  logic [31:0] iram_axi_awaddr,
  input  logic [2:0]  iram_axi_awprot,
  input  logic        iram_axi_awvalid,
  output logic        iram_axi_awready,
  input  logic [31:0] iram_axi_wdata,
  input  logic [3:0]  iram_axi_wstrb,
  input  logic        iram_axi_wvalid,
  output logic        iram_axi_wready,
  output logic [1:0]  iram_axi_bresp,
  output logic        iram_axi_bvalid,
  input  logic        iram_axi_bready,
  input  logic [31:0] iram_axi_araddr,
  input  logic [2:0]  iram_axi_arprot,
  input  logic        iram_axi_arvalid,
  output logic        iram_axi_arready,
  output logic [31:0] iram_axi_rdata,
  output logic [1:0]  iram_axi_rresp,
  output logic        iram_axi_rvalid,
  input  logic        iram_axi_rready
);
  localparam int AW = clogb2(DEPTH);
  localparam int HW = clogb2(RST_HOLD + 1);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [31:0]   pc_q, pc_d;
  logic          aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [31:0]   aw_addr_q, aw_addr_d, w_data_q, w_data_d;
  logic [3:0]    w_strb_q, w_strb_d;
  logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          rd_busy_q, rd_busy_d, rd_err_q, rd_err_d;

  logic          hold, fetch_en, aw_ready, w_ready, ar_ready;
  logic          aw_fire, w_fire, ar_fire, wr_go, wr_err, rd_err, b_en;
  logic [31:0]   fetch_off, wr_addr, wr_data, wr_off, rd_off, b_dout;
  logic [3:0]    wr_strb, b_we;
  logic [AW-1:0] fetch_idx, b_idx;
  logic          unused_bits;

  assign hold      = (hold_cnt_q != '0);
  assign fetch_off = (hold ? BOOT_ADDR : pc_n_i) - BASE_ADDR;
  assign fetch_idx = fetch_off[AW+1:2];
  assign fetch_en  = hold | iram_rd_i;

  // Valid/ready: a beat transfers on the rising edge where both are high; this
  // slave never lowers a valid before its ready, and readies may follow valids.
  assign aw_ready = ~rst & ~aw_full_q & ~bvalid_q;
  assign w_ready  = ~rst & ~w_full_q & ~bvalid_q;
  assign aw_fire  = iram_axi_awvalid & aw_ready;
  assign w_fire   = iram_axi_wvalid & w_ready;
  assign wr_addr  = aw_full_q ? aw_addr_q : iram_axi_awaddr;
  assign wr_data  = w_full_q ? w_data_q : iram_axi_wdata;
  assign wr_strb  = w_full_q ? w_strb_q : iram_axi_wstrb;
  assign wr_go    = (aw_full_q | aw_fire) & (w_full_q | w_fire);
  assign wr_off   = wr_addr - BASE_ADDR;

  // Reads yield to a write issuing this cycle and wait for a free R slot.
  assign ar_ready = ~rst & ~wr_go & (~rvalid_q | iram_axi_rready) & ~rd_busy_q;
  assign ar_fire  = iram_axi_arvalid & ar_ready;
  assign rd_off   = iram_axi_araddr - BASE_ADDR;

`ifdef IRAM_SLVERR_EN
  assign wr_err = |wr_off[31:AW+2];
  assign rd_err = |rd_off[31:AW+2];
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign b_en  = wr_go | ar_fire;
  assign b_we  = (wr_go & ~wr_err) ? wr_strb : 4'b0000;
  assign b_idx = wr_go ? wr_off[AW+1:2] : rd_off[AW+1:2];

  assign unused_bits = ^{iram_axi_awprot, iram_axi_arprot, fetch_off, wr_off, rd_off};

  iram_axi_mp_dpram #(.RAM_WIDTH(32), .RAM_DEPTH(DEPTH), .ADDR_W(AW)) u_ram (
    .clk     (clk),
    .ena_i   (fetch_en),
    .addra_i (fetch_idx),
    .douta_o (inst_o),
    .enb_i   (b_en),
    .web_i   (b_we),
    .addrb_i (b_idx),
    .dinb_i  (wr_data),
    .doutb_o (b_dout)
  );

  always_comb begin
    hold_cnt_d = hold ? hold_cnt_q - HW'(1) : hold_cnt_q;
    pc_d       = hold ? BOOT_ADDR : (iram_rd_i ? pc_n_i : pc_q);
    aw_full_d  = aw_full_q;
    aw_addr_d  = aw_addr_q;
    w_full_d   = w_full_q;
    w_data_d   = w_data_q;
    w_strb_d   = w_strb_q;
    if (wr_go) begin
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end else begin
      if (aw_fire) begin
        aw_full_d = 1'b1;
        aw_addr_d = iram_axi_awaddr;
      end
      if (w_fire) begin
        w_full_d = 1'b1;
        w_data_d = iram_axi_wdata;
        w_strb_d = iram_axi_wstrb;
      end
    end
    bvalid_d = bvalid_q & ~iram_axi_bready;
    bresp_d  = bresp_q;
    if (wr_go) begin
      bvalid_d = 1'b1;
      bresp_d  = wr_err ? RESP_SLVERR : RESP_OKAY;
    end
    rd_busy_d = ar_fire;
    rd_err_d  = ar_fire ? rd_err : rd_err_q;
    rvalid_d  = rvalid_q & ~iram_axi_rready;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    // RAM output is valid the cycle after the AR handshake; capture it then.
    if (rd_busy_q) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_err_q ? 32'h0 : b_dout;
      rresp_d  = rd_err_q ? RESP_SLVERR : RESP_OKAY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q <= HW'(RST_HOLD);
      pc_q       <= BOOT_ADDR;
      aw_full_q  <= 1'b0;
      aw_addr_q  <= 32'h0;
      w_full_q   <= 1'b0;
      w_data_q   <= 32'h0;
      w_strb_q   <= 4'h0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      rd_busy_q  <= 1'b0;
      rd_err_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= 32'h0;
      rresp_q    <= RESP_OKAY;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      pc_q       <= pc_d;
      aw_full_q  <= aw_full_d;
      aw_addr_q  <= aw_addr_d;
      w_full_q   <= w_full_d;
      w_data_q   <= w_data_d;
      w_strb_q   <= w_strb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
      rd_busy_q  <= rd_busy_d;
      rd_err_q   <= rd_err_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign pc_o             = pc_q;
  assign iram_hold_o      = hold;
  assign iram_axi_awready = aw_ready;
  assign iram_axi_wready  = w_ready;
  assign iram_axi_arready = ar_ready;
  assign iram_axi_bvalid  = bvalid_q;
  assign iram_axi_bresp   = bresp_q;
  assign iram_axi_rvalid  = rvalid_q;
  assign iram_axi_rdata   = rdata_q;
  assign iram_axi_rresp   = rresp_q;
endmodule

// File: tb/tb_iram_axi_mp.sv
// Testbench for iram_axi_mp: directed and random AXI/fetch traffic checked
// against a word-array model of the RAM and an expected read-data queue.
module tb_iram_axi_mp;
  localparam int          DEPTH    = 4096;
  localparam logic [31:0] BASE     = 32'h0000_0000;
  localparam logic [31:0] BOOT     = 32'h0000_0000;
  localparam int          RST_HOLD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_n_i;
  logic        iram_rd_i;
  logic [31:0] pc_o, inst_o;
  logic        iram_hold_o;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int total = 0;
  int bad   = 0;
  logic [31:0] mem_m [int];
  logic [31:0] exp_q [$];

  iram_axi_mp #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .BOOT_ADDR(BOOT), .RST_HOLD(RST_HOLD)) dut (
    .clk(clk), .rst(rst), .pc_n_i(pc_n_i), .iram_rd_i(iram_rd_i), .pc_o(pc_o),
    .inst_o(inst_o), .iram_hold_o(iram_hold_o),
    .iram_axi_awaddr(awaddr), .iram_axi_awprot(awprot), .iram_axi_awvalid(awvalid),
    .iram_axi_awready(awready), .iram_axi_wdata(wdata), .iram_axi_wstrb(wstrb),
    .iram_axi_wvalid(wvalid), .iram_axi_wready(wready), .iram_axi_bresp(bresp),
    .iram_axi_bvalid(bvalid), .iram_axi_bready(bready), .iram_axi_araddr(araddr),
    .iram_axi_arprot(arprot), .iram_axi_arvalid(arvalid), .iram_axi_arready(arready),
    .iram_axi_rdata(rdata), .iram_axi_rresp(rresp), .iram_axi_rvalid(rvalid),
    .iram_axi_rready(rready)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic bit addr_err(input logic [31:0] a);
`ifdef IRAM_SLVERR_EN
    return (a - BASE) >= 32'(DEPTH * 4);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'(((a - BASE) / 4) % DEPTH);
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (addr_err(a)) return;
    w = mem_m.exists(widx(a)) ? mem_m[widx(a)] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    mem_m[widx(a)] = w;
  endtask

  // ---------------- scoreboard check ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W; 0: together.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdly);
    int aw_at, w_at, c;
    bit aw_done, w_done, aw_hs, w_hs;
    aw_at = (lead > 0) ? lead : 0;
    w_at  = (lead < 0) ? -lead : 0;
    aw_done = 0; w_done = 0; c = 0;
    while (!(aw_done && w_done) && c < 50) begin
      awvalid = !aw_done && (c >= aw_at);
      awaddr  = a;
      wvalid  = !w_done && (c >= w_at);
      wdata   = d;
      wstrb   = s;
      #1;
      aw_hs = awvalid & awready;
      w_hs  = wvalid & wready;
      @(posedge clk);
      #1;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      c++;
    end
    awvalid = 0;
    wvalid  = 0;
    check("aw_w_handshake", {30'b0, aw_done, w_done}, 32'h3);
    check("bvalid_after_write", 32'(bvalid), 32'h1);
    check("bresp", 32'(bresp), addr_err(a) ? 32'h2 : 32'h0);
    model_write(a, d, s);
    repeat (bdly) begin
      tick();
      check("bvalid_held", 32'(bvalid), 32'h1);
      check("awready_blocked", 32'(awready), 32'h0);
    end
    bready = 1;
    tick();
    bready = 0;
    check("bvalid_cleared", 32'(bvalid), 32'h0);
  endtask

  task automatic axi_read(input logic [31:0] a, input int rdly);
    int c;
    bit hs, hs_now;
    logic [31:0] exp;
    logic [1:0] exp_resp;
    arvalid = 1;
    araddr  = a;
    c = 0; hs = 0;
    while (!hs && c < 50) begin
      #1;
      hs_now = arready;
      @(posedge clk);
      #1;
      hs = hs_now;
      c++;
    end
    arvalid = 0;
    check("ar_handshake", 32'(hs), 32'h1);
    exp_q.push_back(addr_err(a) ? 32'h0 : mem_m[widx(a)]);
    exp_resp = addr_err(a) ? 2'b10 : 2'b00;
    check("rvalid_t1_low", 32'(rvalid), 32'h0);
    tick();
    check("rvalid_t2_high", 32'(rvalid), 32'h1);
    exp = exp_q.pop_front();
    check("rdata", rdata, exp);
    check("rresp", 32'(rresp), 32'(exp_resp));
    repeat (rdly) begin
      tick();
      check("rvalid_held", 32'(rvalid), 32'h1);
      check("rdata_stable", rdata, exp);
    end
    rready = 1;
    tick();
    rready = 0;
    check("rvalid_cleared", 32'(rvalid), 32'h0);
  endtask

  task automatic fetch(input logic [31:0] a);
    pc_n_i    = a;
    iram_rd_i = 1;
    tick();
    iram_rd_i = 0;
    check("fetch_pc", pc_o, a);
    check("fetch_inst", inst_o, mem_m[widx(a)]);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] a, d, old_v, new_v;
    rst = 1; pc_n_i = 0; iram_rd_i = 0;
    awaddr = 0; awprot = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc_o, BOOT);
    check("rst_hold", 32'(iram_hold_o), 32'h1);
    check("rst_readies", {29'b0, awready, wready, arready}, 32'h0);
    check("rst_valids", {30'b0, bvalid, rvalid}, 32'h0);
    check("rst_resps", {28'b0, bresp, rresp}, 32'h0);
    check("rst_rdata", rdata, 32'h0);

    // Hold window: two cycles after release, fetch blocked at BOOT
    pc_n_i = 32'h8; iram_rd_i = 1;
    rst = 0;
    check("hold_c0", 32'(iram_hold_o), 32'h1);
    tick();
    check("hold_c1", 32'(iram_hold_o), 32'h1);
    check("hold_pc_c1", pc_o, BOOT);
    tick();
    check("hold_c2_released", 32'(iram_hold_o), 32'h0);
    check("hold_pc_c2", pc_o, BOOT);
    tick();
    check("first_fetch_pc", pc_o, 32'h8);
    iram_rd_i = 0;

    // Fill words 0..15 with random data and mixed AW/W ordering
    for (int i = 0; i < 16; i++)
      axi_write(32'(i * 4), $urandom, 4'hF, int'($urandom_range(0, 4)) - 2, $urandom_range(0, 2));

    // W three cycles ahead of AW
    axi_write(32'h10, 32'hDEAD_BEEF, 4'hF, 3, 0);
    fetch(32'h10);
    check("fetch_deadbeef", inst_o, 32'hDEAD_BEEF);

    // Byte-lane merge
    axi_write(32'h10, 32'h0000_AA00, 4'b0010, 0, 1);
    fetch(32'h10);
    check("byte1_merge", inst_o, 32'hDEAD_AAEF);
    check("fetch_held_pc", pc_o, 32'h10);

    // Read with rready held low for 5 cycles
    axi_read(32'h10, 5);

    // AW+W+AR together: write wins, read follows with the new data
    new_v = $urandom;
    awaddr = 32'h20; awvalid = 1; wdata = new_v; wstrb = 4'hF; wvalid = 1;
    araddr = 32'h20; arvalid = 1;
    #1;
    check("sim_write_ready", {30'b0, awready, wready}, 32'h3);
    check("sim_ar_blocked", 32'(arready), 32'h0);
    tick();
    awvalid = 0; wvalid = 0;
    model_write(32'h20, new_v, 4'hF);
    check("sim_bvalid", 32'(bvalid), 32'h1);
    check("sim_ar_ready", 32'(arready), 32'h1);
    bready = 1;
    tick();
    arvalid = 0; bready = 0;
    check("sim_bvalid_cleared", 32'(bvalid), 32'h0);
    check("sim_rvalid_t1", 32'(rvalid), 32'h0);
    tick();
    check("sim_rvalid_t2", 32'(rvalid), 32'h1);
    check("sim_rdata_new", rdata, new_v);
    rready = 1;
    tick();
    rready = 0;

    // Fetch/write collision on one word: fetch sees the old contents
    old_v = mem_m[widx(32'h30)];
    new_v = ~old_v;
    wdata = new_v; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    awaddr = 32'h30; awvalid = 1; pc_n_i = 32'h30; iram_rd_i = 1;
    #1;
    check("coll_awready", 32'(awready), 32'h1);
    tick();
    awvalid = 0; iram_rd_i = 0;
    check("coll_old_data", inst_o, old_v);
    check("coll_bvalid", 32'(bvalid), 32'h1);
    model_write(32'h30, new_v, 4'hF);
    bready = 1;
    tick();
    bready = 0;
    fetch(32'h30);

    // Index wrap on fetch, and out-of-range AXI access (wrap or SLVERR)
    fetch(32'(DEPTH * 4) + 32'h10);
    axi_write(BASE + 32'h4000, $urandom, 4'hF, 0, 0);
    axi_read(BASE + 32'h4000, 1);
    fetch(32'h0);

    // Random traffic
    for (int i = 0; i < 24; i++) begin
      a = 32'($urandom_range(0, 15) * 4);
      if ($urandom_range(0, 3) == 0) a = a + 32'(DEPTH * 4);
      d = $urandom;
      axi_write(a, d, 4'($urandom_range(1, 15)), int'($urandom_range(0, 4)) - 2,
                $urandom_range(0, 2));
      axi_read(32'($urandom_range(0, 15) * 4), $urandom_range(0, 3));
      fetch(32'($urandom_range(0, 15) * 4));
    end

    // Reset in the middle of a write: buffered W dropped, RAM preserved
    wdata = 32'h1234_5678; wstrb = 4'hF; wvalid = 1;
    tick();
    wvalid = 0;
    rst = 1;
    #1;
    check("midrst_wready", 32'(wready), 32'h0);
    check("midrst_bvalid", 32'(bvalid), 32'h0);
    tick();
    rst = 0;
    tick();
    tick();
    check("midrst_hold_done", 32'(iram_hold_o), 32'h0);
    check("midrst_buffers_empty", {30'b0, awready, wready}, 32'h3);
    fetch(32'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
